// File: rtl/serial_io_shifter.sv
// Drives the LED shift chain and reads the DIP load chain on one shared serial clock; one transfer per accept.
// Accept to o_DIP_valid is 2*LATCH_CYC + 2*CLK_DIV*DATA_W + 1 cycles; o_LED_ready is low while busy and requests then are dropped.
module serial_io_shifter #(
   parameter int DATA_W    = 8,
   parameter int CLK_DIV   = 5,
   parameter int LATCH_CYC = 2
) (
   input  logic              i_CLK,
   input  logic              i_SYS_RESET,
   input  logic [DATA_W-1:0] i_LED_data,
   input  logic              i_LED_valid,
   output logic              o_LED_ready,
   output logic [DATA_W-1:0] o_DIP_data,
   output logic              o_DIP_valid,
   output logic              o_busy,
   output logic              o_SCLK,
   output logic              o_LEDData,
   output logic              o_LEDLatch,
   output logic              o_DIPLatch,
   input  logic              i_DIPData
);
   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int LAT_W = (LATCH_CYC > 1) ? $clog2(LATCH_CYC) : 1;
   localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   typedef enum logic [2:0] {IDLE, LOAD, SHIFT, LATCH, DONE} state_t;
   state_t state, state_nxt;

   logic [DATA_W-1:0] tx_sr, rx_sr;
   logic [DIV_W-1:0]  div_cnt;
   logic [LAT_W-1:0]  lat_cnt;
   logic [BIT_W-1:0]  bit_cnt;
   logic              phase_hi;
   logic              led_q;
   logic              accept, div_last, lat_last, bit_last;

   assign accept   = i_LED_valid & o_LED_ready;
   assign div_last = (div_cnt == DIV_W'(CLK_DIV - 1));
   assign lat_last = (lat_cnt == LAT_W'(LATCH_CYC - 1));
   assign bit_last = (bit_cnt == '0);

   always_ff @(posedge i_CLK or negedge i_SYS_RESET) begin
      if (!i_SYS_RESET) state <= IDLE;
      else              state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = LOAD;
         LOAD:    if (lat_last) state_nxt = SHIFT;
         SHIFT:   if (phase_hi && div_last && bit_last) state_nxt = LATCH;
         LATCH:   if (lat_last) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      o_LED_ready = 1'b0;
      o_DIPLatch  = 1'b0;
      o_LEDLatch  = 1'b0;
      o_SCLK      = 1'b0;
      o_DIP_valid = 1'b0;
      case (state)
         IDLE:    o_LED_ready = 1'b1;
         LOAD:    o_DIPLatch  = 1'b1;
         SHIFT:   o_SCLK      = phase_hi;
         LATCH:   o_LEDLatch  = 1'b1;
         DONE:    o_DIP_valid = 1'b1;
         default: ;
      endcase
   end

   assign o_busy = ~o_LED_ready;
   // Outside SHIFT the pin holds the last bit driven, since tx_sr has shifted past it.
   assign o_LEDData = (state == SHIFT) ? tx_sr[DATA_W-1] : led_q;

   always_ff @(posedge i_CLK or negedge i_SYS_RESET) begin
      if (!i_SYS_RESET) begin
         tx_sr      <= '0;
         rx_sr      <= '0;
         div_cnt    <= '0;
         lat_cnt    <= '0;
         bit_cnt    <= '0;
         phase_hi   <= 1'b0;
         led_q      <= 1'b0;
         o_DIP_data <= '0;
      end else begin
         if (accept) begin
            tx_sr   <= i_LED_data;
            bit_cnt <= BIT_W'(DATA_W - 1);
         end
         if (state == LOAD || state == LATCH)
            lat_cnt <= lat_last ? '0 : lat_cnt + 1'b1;
         if (state == SHIFT) begin
            led_q   <= tx_sr[DATA_W-1];
            div_cnt <= div_last ? '0 : div_cnt + 1'b1;
            if (div_last) phase_hi <= ~phase_hi;
            // Sample just before the rising edge; advance the LED word just after the falling edge.
            if (div_last && !phase_hi)
               rx_sr <= DATA_W'({rx_sr, i_DIPData});
            if (div_last && phase_hi) begin
               tx_sr <= tx_sr << 1;
               if (!bit_last) bit_cnt <= bit_cnt - 1'b1;
            end
         end
         if (state == LATCH && lat_last)
            o_DIP_data <= rx_sr;
      end
   end
endmodule

// File: tb/tb_serial_io_shifter.sv
// Scoreboard bench: default-parameter instance plus a CLK_DIV=1, DATA_W=4 instance, each with a DIP chain model.
`timescale 1ns/1ps
module tb_serial_io_shifter;
   localparam int W  = 8;
   localparam int CD = 5;
   localparam int LC = 2;
   localparam int LAT_A = 2*LC + 2*CD*W + 1;
   localparam int WB = 4;
   localparam int LAT_B = 2*LC + 2*1*WB + 1;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [W-1:0] a_led_data = '0, a_dip_data, a_dip_pat = '0, a_dip_sr = '0;
   logic a_led_valid = 1'b0, a_ready, a_dip_valid, a_busy, a_sclk, a_led_bit, a_led_latch, a_dip_latch, a_dip_bit;
   logic [WB-1:0] b_led_data = '0, b_dip_data, b_dip_pat = '0, b_dip_sr = '0;
   logic b_led_valid = 1'b0, b_ready, b_dip_valid, b_busy, b_sclk, b_led_bit, b_led_latch, b_dip_latch, b_dip_bit;

   serial_io_shifter dut_a (
      .i_CLK(clk), .i_SYS_RESET(rst_n), .i_LED_data(a_led_data), .i_LED_valid(a_led_valid),
      .o_LED_ready(a_ready), .o_DIP_data(a_dip_data), .o_DIP_valid(a_dip_valid), .o_busy(a_busy),
      .o_SCLK(a_sclk), .o_LEDData(a_led_bit), .o_LEDLatch(a_led_latch), .o_DIPLatch(a_dip_latch),
      .i_DIPData(a_dip_bit));

   serial_io_shifter #(.DATA_W(WB), .CLK_DIV(1), .LATCH_CYC(2)) dut_b (
      .i_CLK(clk), .i_SYS_RESET(rst_n), .i_LED_data(b_led_data), .i_LED_valid(b_led_valid),
      .o_LED_ready(b_ready), .o_DIP_data(b_dip_data), .o_DIP_valid(b_dip_valid), .o_busy(b_busy),
      .o_SCLK(b_sclk), .o_LEDData(b_led_bit), .o_LEDLatch(b_led_latch), .o_DIPLatch(b_dip_latch),
      .i_DIPData(b_dip_bit));

   // DIP chain models: parallel load on latch, shift MSB-first on each serial clock rise.
   always @(posedge a_dip_latch or posedge a_sclk)
      if (a_dip_latch) a_dip_sr <= a_dip_pat;
      else             a_dip_sr <= a_dip_sr << 1;
   assign a_dip_bit = a_dip_sr[W-1];
   always @(posedge b_dip_latch or posedge b_sclk)
      if (b_dip_latch) b_dip_sr <= b_dip_pat;
      else             b_dip_sr <= b_dip_sr << 1;
   assign b_dip_bit = b_dip_sr[WB-1];

   int n_checks = 0;
   int n_fail = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   typedef struct { logic [7:0] dip; int acc; } sb_t;
   sb_t  sb_a[$];
   sb_t  sb_b[$];
   logic led_exp_a[$];
   logic led_exp_b[$];

   int cyc = 0;
   always @(posedge clk) cyc++;

   int a_acc_cnt = 0, a_dv_cnt = 0, a_prev_acc = 0, a_last_acc = 0, a_ll_total = 0, a_sclk_viol = 0;
   int a_dl_first = 0, a_dl_cnt = 0, a_ll_first = 0, a_ll_cnt = 0, a_sc_first = 0, a_sc_last = 0;
   logic a_sclk_d = 1'b0;

   always @(negedge clk) begin
      int rel;
      sb_t e;
      if (rst_n) begin
         if (a_led_valid && a_ready) begin
            a_acc_cnt++;
            a_prev_acc = a_last_acc;
            a_last_acc = cyc + 1;
            sb_a.push_back('{dip: a_dip_pat, acc: cyc + 1});
            for (int i = W-1; i >= 0; i--) led_exp_a.push_back(a_led_data[i]);
            a_dl_first = 0; a_dl_cnt = 0; a_ll_first = 0; a_ll_cnt = 0; a_sc_first = 0; a_sc_last = 0;
         end
         rel = cyc - a_last_acc + 1;
         if (a_dip_latch) begin
            if (a_dl_cnt == 0) a_dl_first = rel;
            a_dl_cnt++;
         end
         if (a_led_latch) begin
            if (a_ll_cnt == 0) a_ll_first = rel;
            a_ll_cnt++;
            a_ll_total++;
         end
         if ((a_dip_latch || a_led_latch) && a_sclk) a_sclk_viol++;
         if (a_sclk) a_sc_last = rel;
         if (a_sclk && !a_sclk_d) begin
            if (a_sc_first == 0) a_sc_first = rel;
            if (led_exp_a.size() == 0) check("a_led_bit_unexpected", led_exp_a.size(), 1);
            else check("a_led_bit", a_led_bit, led_exp_a.pop_front());
         end
         if (a_dip_valid) begin
            a_dv_cnt++;
            if (sb_a.size() == 0) check("a_dip_valid_unexpected", sb_a.size(), 1);
            else begin
               e = sb_a.pop_front();
               check("a_dip_data", a_dip_data, e.dip);
               check("a_latency", cyc - e.acc + 1, LAT_A);
               check("a_diplatch_start", a_dl_first, 1);
               check("a_diplatch_width", a_dl_cnt, LC);
               check("a_first_sclk_rise", a_sc_first, LC + CD + 1);
               check("a_last_sclk_high", a_sc_last, LC + 2*CD*W);
               check("a_ledlatch_start", a_ll_first, LC + 2*CD*W + 1);
               check("a_ledlatch_width", a_ll_cnt, LC);
            end
         end
      end
      a_sclk_d = a_sclk;
   end

   int b_acc_cnt = 0, b_dv_cnt = 0, b_rise_prev = 0;
   logic b_sclk_d = 1'b0;

   always @(negedge clk) begin
      sb_t e;
      if (rst_n) begin
         if (b_led_valid && b_ready) begin
            b_acc_cnt++;
            sb_b.push_back('{dip: 8'(b_dip_pat), acc: cyc + 1});
            for (int i = WB-1; i >= 0; i--) led_exp_b.push_back(b_led_data[i]);
            b_rise_prev = 0;
         end
         if (b_sclk && !b_sclk_d) begin
            if (b_rise_prev != 0) check("b_sclk_period", cyc - b_rise_prev, 2);
            b_rise_prev = cyc;
            if (led_exp_b.size() == 0) check("b_led_bit_unexpected", led_exp_b.size(), 1);
            else check("b_led_bit", b_led_bit, led_exp_b.pop_front());
         end
         if (b_dip_valid) begin
            b_dv_cnt++;
            if (sb_b.size() == 0) check("b_dip_valid_unexpected", sb_b.size(), 1);
            else begin
               e = sb_b.pop_front();
               check("b_dip_data", b_dip_data, e.dip);
               check("b_latency", cyc - e.acc + 1, LAT_B);
            end
         end
      end
      b_sclk_d = b_sclk;
   end

   task automatic wait_acc_a(input int target);
      int n = 0;
      while (a_acc_cnt < target && n < 300) begin @(posedge clk); n++; end
      if (n >= 300) check("a_accept_timeout", a_acc_cnt, target);
   endtask

   task automatic send_a(input logic [W-1:0] d, input logic [W-1:0] dip);
      @(posedge clk); #1;
      a_led_data = d; a_dip_pat = dip; a_led_valid = 1'b1;
      wait_acc_a(a_acc_cnt + 1);
      #1 a_led_valid = 1'b0;
   endtask

   task automatic wait_dv_a(input int target);
      int n = 0;
      while (a_dv_cnt < target && n < 400) begin @(posedge clk); n++; end
      if (n >= 400) check("a_dip_valid_timeout", a_dv_cnt, target);
      repeat (3) @(posedge clk);
      #1;
   endtask

   int exp_a = 0;

   initial begin
      int n;
      repeat (3) @(posedge clk);
      #1;
      check("rst_ready", a_ready, 1);
      check("rst_busy", a_busy, 0);
      check("rst_sclk", a_sclk, 0);
      check("rst_led_bit", a_led_bit, 0);
      check("rst_latches", {a_led_latch, a_dip_latch, a_dip_valid}, 0);
      check("rst_dip_data", a_dip_data, 0);
      @(negedge clk) rst_n = 1'b1;

      // single transfer, LED A5 / DIP 3C
      send_a(8'hA5, 8'h3C); exp_a++;
      wait_dv_a(exp_a);
      check("a_dip_hold", a_dip_data, 8'h3C);
      check("a_led_hold_idle", a_led_bit, 1);
      check("a_ready_after", a_ready, 1);

      // valid held high: FF then 00, data changed right after the first accept
      @(posedge clk); #1;
      a_dip_pat = 8'h5A; a_led_data = 8'hFF; a_led_valid = 1'b1;
      wait_acc_a(exp_a + 1);
      #1 a_led_data = 8'h00;
      wait_acc_a(exp_a + 2);
      #1 a_led_valid = 1'b0;
      exp_a += 2;
      check("a_b2b_spacing", a_last_acc - a_prev_acc, LAT_A + 1);
      wait_dv_a(exp_a);

      // request while busy is dropped
      send_a(8'h81, 8'h18); exp_a++;
      repeat (20) @(posedge clk);
      #1;
      check("a_busy_mid", a_busy, 1);
      a_led_data = 8'hFF; a_led_valid = 1'b1;
      @(posedge clk); #1 a_led_valid = 1'b0;
      wait_dv_a(exp_a);
      repeat (120) @(posedge clk);
      #1;
      check("a_no_queued_accept", a_acc_cnt, exp_a);
      check("a_no_queued_valid", a_dv_cnt, exp_a);
      check("a_sclk_low_in_latch", a_sclk_viol, 0);

      // CLK_DIV=1, DATA_W=4 instance
      @(posedge clk); #1;
      b_led_data = 4'h9; b_dip_pat = 4'h6; b_led_valid = 1'b1;
      n = 0;
      while (b_acc_cnt < 1 && n < 50) begin @(posedge clk); n++; end
      #1 b_led_valid = 1'b0;
      n = 0;
      while (b_dv_cnt < 1 && n < 100) begin @(posedge clk); n++; end
      if (n >= 100) check("b_dip_valid_timeout", b_dv_cnt, 1);
      repeat (5) @(posedge clk);
      #1;
      check("b_dip_hold", b_dip_data, 4'h6);

      // reset in the middle of SHIFT
      send_a(8'hC3, 8'hE7);
      repeat (30) @(posedge clk);
      #1;
      check("a_shift_before_abort", a_busy, 1);
      n = a_ll_total;
      rst_n = 1'b0;
      #2;
      check("abort_ready", a_ready, 1);
      check("abort_busy", a_busy, 0);
      check("abort_sclk", a_sclk, 0);
      check("abort_led_bit", a_led_bit, 0);
      check("abort_dip_data", a_dip_data, 0);
      sb_a.delete(); led_exp_a.delete();
      repeat (3) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      repeat (100) @(posedge clk);
      #1;
      check("abort_no_ledlatch", a_ll_total, n);
      check("abort_no_dip_valid", a_dv_cnt, exp_a);
      check("abort_idle_ready", a_ready, 1);

      // restart after abort
      send_a(8'h3C, 8'h96); exp_a++;
      wait_dv_a(exp_a);
      check("a_total_transfers", a_dv_cnt, exp_a);
      check("a_led_queue_drained", led_exp_a.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
      $fatal(1, "watchdog");
   end
endmodule
